// File: rtl/hht_pkg.sv
// hht_pkg: FSM state type, parameter defaults and unmapped-memory sentinel for hht_fetch_sched
package hht_pkg;
    typedef enum logic [1:0] {IDLE, LOAD_V, STREAM, FIN} state_e;
    localparam int V_SIZE_DEF = 9;
    localparam int DW_DEF = 32;
    localparam int AW_DEF = 32;
    localparam logic [31:0] SENTINEL = 32'd99999;
endpackage

// File: rtl/hht_out_reg.sv
// hht_out_reg: one-entry valid/ready holding register; an empty register passes the incoming word straight through
module hht_out_reg #(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_data_i,
    output logic          in_ready_o,
    output logic          out_valid_o,
    output logic [DW-1:0] out_data_o,
    input  logic          out_ready_i
);
    logic          full_q, full_d, load;
    logic [DW-1:0] data_q;
    // capture when a stalled pass-through must be held, or when the held word leaves as a new one arrives
    always_comb begin
        load = in_valid_i && (full_q == out_ready_i);
        full_d = load || (full_q && !out_ready_i);
        in_ready_o = !full_q || out_ready_i;
        out_valid_o = full_q || in_valid_i;
        out_data_o = full_q ? data_q : in_valid_i ? in_data_i : '0;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            if (load) data_q <= in_data_i;
        end
    end
endmodule

// File: rtl/hht_fetch_sched.sv
// hht_fetch_sched: loads V_SIZE v-values then streams csize column words over one shared memory read port.
// Define HHT_FETCH_CHECK_EN to flag reads returning the unmapped-memory sentinel on err_o.
module hht_fetch_sched
    import hht_pkg::*;
#(
    parameter int V_SIZE = V_SIZE_DEF,
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AW-1:0]        v_values_base_i,
    input  logic [AW-1:0]        wdata_col_base_i,
    input  logic [31:0]          csize_i,
    output logic [AW-1:0]        mem_addr_o,
    output logic                 mem_rd_o,
    input  logic [DW-1:0]        mem_data_i,
    output logic [V_SIZE*DW-1:0] vval_o,
    output logic [DW-1:0]        col_data_o,
    output logic                 col_valid_o,
    input  logic                 col_ready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);
    state_e               state_q, state_d;
    logic [AW-1:0]        vbase_q, cbase_q;
    logic [31:0]          csize_q, k_q, k_d, j_q, j_d, acc_q, acc_d;
    logic [V_SIZE*DW-1:0] vval_q, vval_d;
    logic                 go, load_rd, issue, rd_ready, fire;

    assign load_rd = state_q == LOAD_V;
    assign issue = state_q == STREAM && j_q != csize_q && rd_ready;
    assign fire = col_valid_o && col_ready_i;
    assign mem_rd_o = load_rd || issue;
    assign mem_addr_o = load_rd ? vbase_q + AW'(k_q) : issue ? cbase_q + AW'(j_q) : '0;
    assign busy_o = state_q != IDLE;
    assign done_o = state_q == FIN;
    assign vval_o = vval_q;

    hht_out_reg #(.DW(DW)) u_out (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (issue),
        .in_data_i   (mem_data_i),
        .in_ready_o  (rd_ready),
        .out_valid_o (col_valid_o),
        .out_data_o  (col_data_o),
        .out_ready_i (col_ready_i)
    );

    always_comb begin
        state_d = state_q;
        k_d = k_q;
        j_d = j_q;
        acc_d = acc_q;
        vval_d = vval_q;
        go = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                go = 1'b1;
                state_d = LOAD_V;
                k_d = '0;
                j_d = '0;
                acc_d = '0;
            end
            LOAD_V: begin
                for (int i = 0; i < V_SIZE; i++) if (k_q == 32'(i)) vval_d[i*DW +: DW] = mem_data_i;
                k_d = k_q + 32'd1;
                if (k_q == 32'(V_SIZE - 1)) state_d = csize_q == '0 ? FIN : STREAM;
            end
            STREAM: begin
                if (issue) j_d = j_q + 32'd1;
                if (fire) acc_d = acc_q + 32'd1;
                if (fire && acc_q == csize_q - 32'd1) state_d = FIN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            vbase_q <= '0;
            cbase_q <= '0;
            csize_q <= '0;
            k_q <= '0;
            j_q <= '0;
            acc_q <= '0;
            vval_q <= '0;
        end else begin
            state_q <= state_d;
            k_q <= k_d;
            j_q <= j_d;
            acc_q <= acc_d;
            vval_q <= vval_d;
            if (go) begin
                vbase_q <= v_values_base_i;
                cbase_q <= wdata_col_base_i;
                csize_q <= csize_i;
            end
        end
    end

`ifdef HHT_FETCH_CHECK_EN
    logic err_q, hit;
    assign hit = mem_rd_o && mem_data_i == DW'(SENTINEL);
    assign err_o = err_q || hit;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else if (go) err_q <= 1'b0;
        else if (hit) err_q <= 1'b1;
    end
`else
    assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_hht_fetch_sched.sv
// tb_hht_fetch_sched: scoreboard bench for hht_fetch_sched against a combinational memory model
module tb_hht_fetch_sched;
    localparam int V_SIZE = 9, DW = 32, AW = 32, MEM_N = 2048;
`ifdef HHT_FETCH_CHECK_EN
    localparam bit ERR_EXP = 1'b1;
`else
    localparam bit ERR_EXP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n, start, mem_rd, col_valid, col_ready, busy, done, err;
    logic [AW-1:0] v_values_base, wdata_col_base, mem_addr;
    logic [31:0] csize;
    logic [DW-1:0] mem_data, col_data;
    logic [V_SIZE*DW-1:0] vval;
    logic [31:0] mem [MEM_N];
    logic [DW-1:0] exp_q[$];
    int n_chk = 0, n_err = 0, n_done = 0;
    logic prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always #5 clk = ~clk;
    assign mem_data = mem[mem_addr[10:0]];

    hht_fetch_sched #(.V_SIZE(V_SIZE), .DW(DW), .AW(AW)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .start_i          (start),
        .v_values_base_i  (v_values_base),
        .wdata_col_base_i (wdata_col_base),
        .csize_i          (csize),
        .mem_addr_o       (mem_addr),
        .mem_rd_o         (mem_rd),
        .mem_data_i       (mem_data),
        .vval_o           (vval),
        .col_data_o       (col_data),
        .col_valid_o      (col_valid),
        .col_ready_i      (col_ready),
        .busy_o           (busy),
        .done_o           (done),
        .err_o            (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ctl"}, {59'd0, mem_rd, col_valid, busy, done, err}, 64'd0);
        check({tag, "_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_data"}, 64'(col_data), 64'd0);
        check({tag, "_vval"}, 64'(|vval), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!mem_rd) check("addr_idle", 64'(mem_addr), 64'd0);
        if (mem_rd && mem_addr == 32'd1070) check("err_at_1070", 64'(err), 64'(ERR_EXP));
        if (prev_hold) check("hold", {31'd0, col_valid, col_data}, {31'd0, 1'b1, prev_data});
        if (col_valid && col_ready) begin
            if (exp_q.size() == 0) check("extra_word", 64'(col_valid), 64'd0);
            else check("col_word", 64'(col_data), 64'(exp_q.pop_front()));
        end
        if (done) n_done++;
        prev_hold = rst_n && col_valid && !col_ready;
        prev_data = col_data;
    end

    task automatic run(input logic [31:0] vb, input logic [31:0] cb, input logic [31:0] cs,
                       input bit tog, input bit poke, input int abort_at, input int exp_lat);
        int cnt;
        bit hit = 1'b0;
        exp_q.delete();
        for (int j = 0; j < int'(cs); j++) exp_q.push_back(mem[(int'(cb) + j) % MEM_N]);
        n_done = 0;
        @(posedge clk);
        #1;
        v_values_base = vb;
        wdata_col_base = cb;
        csize = cs;
        start = 1'b1;
        col_ready = 1'b1;
        for (cnt = 1; cnt <= V_SIZE + 2 * int'(cs) + 20; cnt++) begin
            @(posedge clk);
            #1;
            start = poke && cnt == 60;
            v_values_base = 32'd3000;
            wdata_col_base = 32'd3;
            csize = 32'd5;
            col_ready = tog ? !col_ready : 1'b1;
            if (cnt == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_idle("abort");
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                check("abort_no_done", 64'(n_done), 64'd0);
                exp_q.delete();
                return;
            end
            if (done) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            check("run_timeout", 64'(done), 64'd1);
            return;
        end
        if (exp_lat >= 0) check("latency", 64'(cnt), 64'(exp_lat));
        @(negedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", 64'(n_done), 64'd1);
        check("drain", 64'(exp_q.size()), 64'd0);
        check("idle_after", 64'(busy), 64'd0);
        for (int k = 0; k < V_SIZE; k++)
            check($sformatf("vval%0d", k), 64'(vval[k*DW +: DW]), 64'(mem[(int'(vb) + k) % MEM_N]));
    endtask

    initial begin
        int vv[V_SIZE] = '{15, 24, 12, 35, 68, 98, 58, 61, 14};
        for (int i = 0; i < MEM_N; i++) mem[i] = 32'((i * 37 + 11) % 1000);
        for (int k = 0; k < V_SIZE; k++) mem[2 + k] = 32'(vv[k]);
        mem[660] = 32'd45;
        mem[661] = 32'd31;
        mem[662] = 32'd16;
        mem[1070] = 32'd99999;
        rst_n = 1'b0;
        start = 1'b0;
        col_ready = 1'b0;
        v_values_base = '0;
        wdata_col_base = '0;
        csize = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        run(32'd2, 32'd660, 32'd410, 1'b0, 1'b0, -1, 420);
        run(32'd2, 32'd660, 32'd410, 1'b1, 1'b0, -1, -1);
        run(32'd100, 32'd1500, 32'd0, 1'b0, 1'b0, -1, 10);
        run(32'd2, 32'd660, 32'd410, 1'b0, 1'b0, 110, -1);
        run(32'd5, 32'd700, 32'd50, 1'b0, 1'b0, -1, 60);
        run(32'd2, 32'd660, 32'd420, 1'b0, 1'b1, -1, 430);
        check("err_sticky", 64'(err), 64'(ERR_EXP));
        run(32'd2, 32'd660, 32'd3, 1'b0, 1'b0, -1, 13);
        check("err_clear", 64'(err), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        check("vval_hold", 64'(vval[DW-1:0]), 64'(mem[2]));
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_chk, n_err);
        $fatal(1);
    end
endmodule
